// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR and its period monitor.
package lfsr_pkg;

  localparam int LFSR_WIDTH    = 4;
  localparam int DEF_MAX_COUNT = 2 ** LFSR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESULT = 2'd3
  } mon_state_e;

  // Fibonacci step for x^4+x^3+1, shifting toward the MSB.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
    input logic [LFSR_WIDTH-1:0] s
  );
    return {s[LFSR_WIDTH-2:0], s[3] ^ s[2]};
  endfunction

endpackage

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR state stream and
// reports period / lockup / timeout / max-length over valid-ready.
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int WIDTH     = LFSR_WIDTH,
  parameter int CNT_W     = WIDTH + 1,
  parameter int MAX_COUNT = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] lfsr_w,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] period,
  output logic             lockup,
  output logic             timeout,
  output logic             max_len
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] MLEN_C = CNT_W'((2 ** WIDTH) - 1);

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic             lockup_q, lockup_d;
  logic             timeout_q, timeout_d;
  logic             max_len_q, max_len_d;

  logic [CNT_W-1:0] count_nx;
  logic             is_zero;
  logic             hit_ref;
  logic             hit_zero;
  logic             hit_max;

  assign count_nx = count_q + CNT_W'(1);
  assign is_zero  = (lfsr_w == '0);
  assign hit_ref  = (lfsr_w == ref_q);
  assign hit_zero = is_zero && !hit_ref;
  assign hit_max  = (count_nx == MAX_C)
                 && !is_zero && !hit_ref;

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    count_d     = count_q;
    period_d    = period_q;
    res_valid_d = res_valid_q;
    lockup_d    = lockup_q;
    timeout_d   = timeout_q;
    max_len_d   = max_len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ARM;
          lockup_d  = 1'b0;
          timeout_d = 1'b0;
          max_len_d = 1'b0;
        end
      end

      ST_ARM: begin
        if (in_valid) begin
          ref_d   = lfsr_w;
          count_d = '0;
          if (is_zero) begin
            state_d     = ST_RESULT;
            res_valid_d = 1'b1;
            lockup_d    = 1'b1;
            period_d    = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (in_valid) begin
          count_d = count_nx;
          // Terms are made exclusive above: match > lockup > timeout.
          unique case (1'b1)
            hit_ref: begin
              state_d     = ST_RESULT;
              res_valid_d = 1'b1;
              period_d    = count_nx;
              max_len_d   = (count_nx == MLEN_C);
            end
            hit_zero: begin
              state_d     = ST_RESULT;
              res_valid_d = 1'b1;
              lockup_d    = 1'b1;
              period_d    = count_nx;
            end
            hit_max: begin
              state_d     = ST_RESULT;
              res_valid_d = 1'b1;
              timeout_d   = 1'b1;
              period_d    = MAX_C;
            end
            default: ;
          endcase
        end
      end

      ST_RESULT: begin
        if (res_valid_q && res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_ARM)
          || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ref_q       <= '0;
      count_q     <= '0;
      period_q    <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      lockup_q    <= 1'b0;
      timeout_q   <= 1'b0;
      max_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      count_q     <= count_d;
      period_q    <= period_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      lockup_q    <= lockup_d;
      timeout_q   <= timeout_d;
      max_len_q   <= max_len_d;
    end
  end

  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign period    = period_q;
  assign lockup    = lockup_q;
  assign timeout   = timeout_q;
  assign max_len   = max_len_q;

endmodule
